cdb_mul_buffer: RTL and testbench

- Completion buffer on the far side of the dual pipelined multiplier's CDB/PRF output interface.
- Captures up to two multiply completions per cycle from the two mult pipes (result, dest AR/PR index, exception) into an ordered FIFO.
- Requests CDB slots from the CDB arbiter and drains granted entries onto the CDB/PRF write ports.
- Replaces the multiplier's hard-wired always-available signal with credit-based issue flow control back to the RS.

---
 rtl/cdb_mul_buffer.sv | 171 +++++++++++++++++
 tb/tb_cdb_mul_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_mul_buffer.sv
// Ordered completion buffer between the dual multiplier pipes and the CDB/PRF ports.
// Optional same-cycle bypass onto the CDB when empty: define CDB_MUL_BYPASS_EN.
module cdb_mul_buffer #(
  parameter int DEPTH   = 8,
  parameter int PTR_W   = 3,
  parameter int MUL_LAT = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rs_issue0,
  input  logic        rs_issue1,
  input  logic        mul_complete0,
  input  logic        mul_complete1,
  input  logic [63:0] mul_result0,
  input  logic [63:0] mul_result1,
  input  logic [4:0]  mul_dest_ar_idx0,
  input  logic [4:0]  mul_dest_ar_idx1,
  input  logic [6:0]  mul_dest_pr_idx0,
  input  logic [6:0]  mul_dest_pr_idx1,
  input  logic        mul_exception0,
  input  logic        mul_exception1,
  input  logic [1:0]  cdb_grant,
  output logic [1:0]  cdb_req,
  output logic        cdb_complete0,
  output logic        cdb_complete1,
  output logic [4:0]  cdb_dest_ar_idx0,
  output logic [4:0]  cdb_dest_ar_idx1,
  output logic [6:0]  cdb_prf_dest_pr_idx0,
  output logic [6:0]  cdb_prf_dest_pr_idx1,
  output logic        cdb_exception0,
  output logic        cdb_exception1,
  output logic [63:0] prf_result0,
  output logic [63:0] prf_result1,
  output logic        prf_write_enable0,
  output logic        prf_write_enable1,
  output logic [1:0]  rs_mul_avail,
  output logic        overflow_err
);

  localparam int CNT_W = $clog2(DEPTH + 2 * MUL_LAT + 1);
  localparam int UW    = CNT_W + 1;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  ar;
    logic [6:0]  pr;
    logic        exc;
  } ent_t;

  ent_t             mem_q [DEPTH];
  ent_t             mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] infl_q, infl_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       avail_q, avail_d;

  ent_t             in0, in1, pa, pb, s0, s1;
  logic             pva, pvb, pop0, pop1;
  logic             acc_a, acc_b, byp;
  logic [1:0]       req, npop, fpop;
  logic [CNT_W-1:0] space, need, sum_in, done;
  logic [UW-1:0]    used;

  always_comb begin
    in0 = {mul_result0, mul_dest_ar_idx0,
           mul_dest_pr_idx0, mul_exception0};
    in1 = {mul_result1, mul_dest_ar_idx1,
           mul_dest_pr_idx1, mul_exception1};
    // compact arrivals so the older one always leads
    pa  = mul_complete0 ? in0 : in1;
    pva = mul_complete0 | mul_complete1;
    pb  = in1;
    pvb = mul_complete0 & mul_complete1;
    s0  = mem_q[head_q];
    s1  = mem_q[head_q + PTR_W'(1)];
    req = {count_q >= CNT_W'(2), count_q >= CNT_W'(1)};
    byp = 1'b0;
`ifdef CDB_MUL_BYPASS_EN
    byp = (count_q == '0);
    if (byp) begin
      s0  = pa;
      s1  = pb;
      req = {pvb, pva};
    end
`endif
    pop0 = cdb_grant[0] & req[0];
    pop1 = cdb_grant[0] & cdb_grant[1] & req[1];
    npop = {1'b0, pop0} + {1'b0, pop1};
    fpop = byp ? 2'b00 : npop;
`ifdef CDB_MUL_BYPASS_EN
    if (byp) begin
      if (pop1) begin
        pva = 1'b0;
        pvb = 1'b0;
      end else if (pop0) begin
        pa  = pb;
        pva = pvb;
        pvb = 1'b0;
      end
    end
`endif
    space = CNT_W'(DEPTH) - count_q + CNT_W'(fpop);
    acc_a = pva & (space != '0);
    need  = acc_a ? CNT_W'(2) : CNT_W'(1);
    acc_b = pvb & (space >= need);

    mem_d = mem_q;
    if (acc_a) mem_d[tail_q] = pa;
    if (acc_b) mem_d[tail_q + PTR_W'(acc_a)] = pb;

    head_d  = head_q + PTR_W'(fpop);
    tail_d  = tail_q + PTR_W'(acc_a) + PTR_W'(acc_b);
    count_d = count_q + CNT_W'(acc_a) + CNT_W'(acc_b)
            - CNT_W'(fpop);
    ovf_d   = ovf_q | (pva & ~acc_a) | (pvb & ~acc_b);

    sum_in = infl_q + CNT_W'(rs_issue0) + CNT_W'(rs_issue1);
    done   = CNT_W'(mul_complete0) + CNT_W'(mul_complete1);
    infl_d = (sum_in > done) ? sum_in - done : '0;

    // credits reflect the state being loaded this edge
    used = {1'b0, count_d} + {1'b0, infl_d};
    if (used <= UW'(DEPTH - 2))
      avail_d = 2'b11;
    else if (used == UW'(DEPTH - 1))
      avail_d = 2'b01;
    else
      avail_d = 2'b00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      infl_q  <= '0;
      ovf_q   <= 1'b0;
      avail_q <= 2'b11;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      infl_q  <= infl_d;
      ovf_q   <= ovf_d;
      avail_q <= avail_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign cdb_req              = req;
  assign cdb_complete0        = pop0;
  assign cdb_complete1        = pop1;
  assign prf_write_enable0    = pop0;
  assign prf_write_enable1    = pop1;
  assign prf_result0          = s0.res;
  assign prf_result1          = s1.res;
  assign cdb_dest_ar_idx0     = s0.ar;
  assign cdb_dest_ar_idx1     = s1.ar;
  assign cdb_prf_dest_pr_idx0 = s0.pr;
  assign cdb_prf_dest_pr_idx1 = s1.pr;
  assign cdb_exception0       = s0.exc;
  assign cdb_exception1       = s1.exc;
  assign rs_mul_avail         = avail_q;
  assign overflow_err         = ovf_q;

endmodule

// File: tb/tb_cdb_mul_buffer.sv
// Bench for cdb_mul_buffer: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_cdb_mul_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        rs_issue0, rs_issue1;
  logic        mul_complete0, mul_complete1;
  logic [63:0] mul_result0, mul_result1;
  logic [4:0]  mul_dest_ar_idx0, mul_dest_ar_idx1;
  logic [6:0]  mul_dest_pr_idx0, mul_dest_pr_idx1;
  logic        mul_exception0, mul_exception1;
  logic [1:0]  cdb_grant;
  logic [1:0]  cdb_req;
  logic        cdb_complete0, cdb_complete1;
  logic [4:0]  cdb_dest_ar_idx0, cdb_dest_ar_idx1;
  logic [6:0]  cdb_prf_dest_pr_idx0, cdb_prf_dest_pr_idx1;
  logic        cdb_exception0, cdb_exception1;
  logic [63:0] prf_result0, prf_result1;
  logic        prf_write_enable0, prf_write_enable1;
  logic [1:0]  rs_mul_avail;
  logic        overflow_err;

  always #5 clock = ~clock;

  cdb_mul_buffer dut (
    .clock(clock), .reset(reset),
    .rs_issue0(rs_issue0), .rs_issue1(rs_issue1),
    .mul_complete0(mul_complete0), .mul_complete1(mul_complete1),
    .mul_result0(mul_result0), .mul_result1(mul_result1),
    .mul_dest_ar_idx0(mul_dest_ar_idx0),
    .mul_dest_ar_idx1(mul_dest_ar_idx1),
    .mul_dest_pr_idx0(mul_dest_pr_idx0),
    .mul_dest_pr_idx1(mul_dest_pr_idx1),
    .mul_exception0(mul_exception0), .mul_exception1(mul_exception1),
    .cdb_grant(cdb_grant), .cdb_req(cdb_req),
    .cdb_complete0(cdb_complete0), .cdb_complete1(cdb_complete1),
    .cdb_dest_ar_idx0(cdb_dest_ar_idx0),
    .cdb_dest_ar_idx1(cdb_dest_ar_idx1),
    .cdb_prf_dest_pr_idx0(cdb_prf_dest_pr_idx0),
    .cdb_prf_dest_pr_idx1(cdb_prf_dest_pr_idx1),
    .cdb_exception0(cdb_exception0), .cdb_exception1(cdb_exception1),
    .prf_result0(prf_result0), .prf_result1(prf_result1),
    .prf_write_enable0(prf_write_enable0),
    .prf_write_enable1(prf_write_enable1),
    .rs_mul_avail(rs_mul_avail), .overflow_err(overflow_err)
  );

  typedef struct packed {
    logic [63:0] r;
    logic [4:0]  a;
    logic [6:0]  p;
    logic        e;
  } ment_t;

  ment_t      q[$];
  int         infl = 0;
  logic       m_ovf = 1'b0;
  logic [1:0] m_av = 2'b11;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs_issue0 = 0; rs_issue1 = 0;
    mul_complete0 = 0; mul_complete1 = 0;
    mul_result0 = '0; mul_result1 = '0;
    mul_dest_ar_idx0 = '0; mul_dest_ar_idx1 = '0;
    mul_dest_pr_idx0 = '0; mul_dest_pr_idx1 = '0;
    mul_exception0 = 0; mul_exception1 = 0;
  endtask

  task automatic cpl(input bit v0, input bit v1,
                     input logic [63:0] r0, input logic [63:0] r1);
    mul_complete0 = v0; mul_complete1 = v1;
    mul_result0 = r0; mul_result1 = r1;
    mul_dest_ar_idx0 = r0[4:0];  mul_dest_ar_idx1 = r1[4:0];
    mul_dest_pr_idx0 = r0[10:4]; mul_dest_pr_idx1 = r1[10:4];
    mul_exception0 = r0[11];     mul_exception1 = r1[11];
  endtask

  // One clock: check outputs against the model, then advance it.
  task automatic cyc();
    int    n, sp, used;
    bit    p0, p1;
    ment_t inc[$];
    #1;
    n  = q.size();
    p0 = cdb_grant[0] && n >= 1;
    p1 = (cdb_grant == 2'b11) && n >= 2;
    chk("req", cdb_req, {n >= 2, n >= 1});
    chk("cmp0", cdb_complete0, p0);
    chk("cmp1", cdb_complete1, p1);
    chk("we0", prf_write_enable0, p0);
    chk("we1", prf_write_enable1, p1);
    chk("avail", rs_mul_avail, m_av);
    chk("ovf", overflow_err, m_ovf);
    if (n >= 1) begin
      chk("res0", prf_result0, q[0].r);
      chk("tag0", {cdb_dest_ar_idx0, cdb_prf_dest_pr_idx0,
                   cdb_exception0}, {q[0].a, q[0].p, q[0].e});
    end
    if (n >= 2) begin
      chk("res1", prf_result1, q[1].r);
      chk("tag1", {cdb_dest_ar_idx1, cdb_prf_dest_pr_idx1,
                   cdb_exception1}, {q[1].a, q[1].p, q[1].e});
    end
    @(posedge clock);
    if (reset) begin
      q.delete();
      infl  = 0;
      m_ovf = 1'b0;
      m_av  = 2'b11;
    end else begin
      if (p0) void'(q.pop_front());
      if (p1) void'(q.pop_front());
      if (mul_complete0)
        inc.push_back({mul_result0, mul_dest_ar_idx0,
                       mul_dest_pr_idx0, mul_exception0});
      if (mul_complete1)
        inc.push_back({mul_result1, mul_dest_ar_idx1,
                       mul_dest_pr_idx1, mul_exception1});
      foreach (inc[i]) begin
        sp = 8 - q.size();
        if (sp > 0) q.push_back(inc[i]);
        else m_ovf = 1'b1;
      end
      infl = infl + int'(rs_issue0) + int'(rs_issue1)
           - int'(mul_complete0) - int'(mul_complete1);
      if (infl < 0) infl = 0;
      used = q.size() + infl;
      m_av = (used <= 6) ? 2'b11 : (used == 7) ? 2'b01 : 2'b00;
    end
    @(negedge clock);
  endtask

  initial begin
    int         n_iss;
    int         guard;
    int         k;
    logic [1:0] dl0, dl1;
    logic [4:0] p0l, p1l;

    idle();
    cdb_grant = 2'b00;
    reset = 1'b1;
    @(negedge clock);
    cyc();
    cyc();
    reset = 1'b0;

    // idle after reset
    repeat (10) cyc();
    chk("idle_req", cdb_req, 2'b00);
    chk("idle_avail", rs_mul_avail, 2'b11);
    chk("idle_ovf", overflow_err, 1'b0);

    // single completion on pipe 0
    cdb_grant = 2'b11;
    cpl(1, 0, 64'h15, 64'h0);
    mul_dest_pr_idx0 = 7;
    mul_dest_ar_idx0 = 3;
    #1 chk("single_nobypass", cdb_complete0, 1'b0);
    cyc();
    idle();
    #1;
    chk("single_c0", cdb_complete0, 1'b1);
    chk("single_res", prf_result0, 64'h15);
    chk("single_pr", cdb_prf_dest_pr_idx0, 7'd7);
    chk("single_ar", cdb_dest_ar_idx0, 5'd3);
    chk("single_c1", cdb_complete1, 1'b0);
    cyc();

    // both pipes, drained one per cycle on slot 0
    cdb_grant = 2'b01;
    cpl(1, 1, 64'hA, 64'hB);
    cyc();
    idle();
    #1;
    chk("pair_a", prf_result0, 64'hA);
    chk("pair_a_c1", cdb_complete1, 1'b0);
    cyc();
    #1;
    chk("pair_b", prf_result0, 64'hB);
    chk("pair_b_c0", cdb_complete0, 1'b1);
    cyc();

    // consume all credits with no grants
    cdb_grant = 2'b00;
    n_iss = 0;
    guard = 0;
    while (rs_mul_avail != 2'b00 && guard < 20) begin
      rs_issue0 = rs_mul_avail[0];
      rs_issue1 = rs_mul_avail[1];
      n_iss += int'(rs_issue0) + int'(rs_issue1);
      cyc();
      guard++;
    end
    idle();
    chk("fill_issues", n_iss, 8);
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) begin
      cpl(1, 1, 64'h100 + 64'(2 * i), 64'h101 + 64'(2 * i));
      cyc();
    end
    idle();
    chk("full_req", cdb_req, 2'b11);
    chk("full_avail", rs_mul_avail, 2'b00);
    chk("full_noovf", overflow_err, 1'b0);

    // credit violation while full
    cpl(1, 1, 64'hDEAD0, 64'hDEAD1);
    cyc();
    idle();
    chk("ovf_set", overflow_err, 1'b1);
    cyc();
    chk("ovf_sticky", overflow_err, 1'b1);

    // drain across pointer wrap
    cdb_grant = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain0", prf_result0, 64'h100 + 64'(2 * i));
      chk("drain1", prf_result1, 64'h101 + 64'(2 * i));
      cyc();
    end
    chk("drained_req", cdb_req, 2'b00);
    chk("drained_ovf", overflow_err, 1'b1);

    // grant[1] alone pops nothing
    cdb_grant = 2'b00;
    cpl(1, 1, 64'h31, 64'h32);
    cyc();
    cpl(1, 0, 64'h33, 64'h0);
    cyc();
    idle();
    cdb_grant = 2'b10;
    #1;
    chk("g10_c0", cdb_complete0, 1'b0);
    chk("g10_c1", cdb_complete1, 1'b0);
    cyc();
    chk("g10_kept", cdb_req, 2'b11);

    // reset mid-drain
    cdb_grant = 2'b11;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_req", cdb_req, 2'b00);
    chk("rst_avail", rs_mul_avail, 2'b11);
    chk("rst_ovf", overflow_err, 1'b0);

    // random legal traffic, completions MUL_LAT cycles after issue
    p0l = '0;
    p1l = '0;
    for (int c = 0; c < 400; c++) begin
      dl0 = {p0l[4], 1'b0};
      dl1 = {p1l[4], 1'b0};
      cpl(dl0[1], dl1[1], {$urandom, $urandom}, {$urandom, $urandom});
      cdb_grant = 2'($urandom);
      k = (rs_mul_avail == 2'b11) ? $urandom_range(0, 2) :
          (rs_mul_avail == 2'b01) ? $urandom_range(0, 1) : 0;
      if (k == 1 && $urandom_range(0, 1) == 1) begin
        rs_issue0 = 0; rs_issue1 = 1;
      end else begin
        rs_issue0 = (k >= 1); rs_issue1 = (k == 2);
      end
      reset = ($urandom_range(0, 99) == 0);
      if (reset) begin
        rs_issue0 = 0; rs_issue1 = 0;
      end
      p0l = reset ? '0 : {p0l[3:0], rs_issue0};
      p1l = reset ? '0 : {p1l[3:0], rs_issue1};
      cyc();
    end
    reset = 1'b0;
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
